// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared constants and helpers for the SimpleProcessor register file.
//   SP_DATA_W   - default register word width
//   SP_ADDR_W   - default register address width
//   SP_WCNT_MAX - saturation value of the committed-write counter
package reg_file_pkg;

  localparam int unsigned SP_DATA_W   = 8;
  localparam int unsigned SP_ADDR_W   = 3;
  localparam logic [7:0]  SP_WCNT_MAX = 8'hFF;

  // Saturating increment of the write counter; holds at SP_WCNT_MAX.
  function automatic logic [7:0] wcnt_next(input logic [7:0] cnt, input logic inc);
    if (inc && (cnt != SP_WCNT_MAX)) return cnt + 8'd1;
    return cnt;
  endfunction

endpackage

// File: rtl/reg_file_word.sv
// reg_word: one DATA_W-bit register word built from posedge D flip-flops.
//   i_clk  - clock
//   i_rst_ - asynchronous active-low clear
//   i_en   - load enable, sampled on posedge i_clk
//   i_D    - data in
//   o_Q    - registered data out
module reg_word #(
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_D,
  output logic [DATA_W-1:0] o_Q
);

  logic [DATA_W-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_) begin
    if (!i_rst_) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_D;
    end
  end

  assign o_Q = r_q;

endmodule

// File: rtl/reg_file.sv
// reg_file: SimpleProcessor register file, 2 async read ports, 1 sync write port.
//   i_clk              - clock, all state updates on posedge
//   i_rst_             - asynchronous active-low reset (clears registers and o_wcnt)
//   i_we/i_waddr/i_wdata - write port, committed on posedge
//   i_raddrA/i_raddrB  - read addresses, o_rdataA/o_rdataB combinational read data
//   o_wcnt             - saturating count of committed writes
// Parameters: DATA_W, ADDR_W (NREGS = 2**ADDR_W), ZERO_R0 (r0 hardwired to 0).
// Build option: define REGFILE_BYPASS_EN for same-cycle write-through forwarding
// to the read ports; undefined, reads return the old value until the posedge.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int DATA_W  = SP_DATA_W,
  parameter int ADDR_W  = SP_ADDR_W,
  parameter int ZERO_R0 = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddrA,
  input  logic [ADDR_W-1:0] i_raddrB,
  output logic [DATA_W-1:0] o_rdataA,
  output logic [DATA_W-1:0] o_rdataB,
  output logic [7:0]        o_wcnt
);

  localparam int NREGS = 2**ADDR_W;

  logic [DATA_W-1:0] w_q [NREGS];
  logic [NREGS-1:0]  w_wen;
  logic              w_discard;
  logic              w_commit;
  logic [DATA_W-1:0] w_rdA;
  logic [DATA_W-1:0] w_rdB;
  logic [7:0]        r_wcnt;

  // Writes to r0 are dropped entirely when it is hardwired to zero, so they
  // neither load the word nor count as committed.
  assign w_discard = (ZERO_R0 != 0) && (i_waddr == '0);
  assign w_commit  = i_we && !w_discard;

  always_comb begin
    w_wen = '0;
    if (w_commit) w_wen[i_waddr] = 1'b1;
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_word
    reg_word #(
      .DATA_W (DATA_W)
    ) u_word (
      .i_clk  (i_clk),
      .i_rst_ (i_rst_),
      .i_en   (w_wen[g]),
      .i_D    (i_wdata),
      .o_Q    (w_q[g])
    );
  end

  always_comb begin
    w_rdA = w_q[i_raddrA];
    if ((ZERO_R0 != 0) && (i_raddrA == '0)) w_rdA = '0;
  end

  always_comb begin
    w_rdB = w_q[i_raddrB];
    if ((ZERO_R0 != 0) && (i_raddrB == '0)) w_rdB = '0;
  end

`ifdef REGFILE_BYPASS_EN
  // Forwarding is masked during reset so reads stay 0 while i_rst_ is low.
  always_comb begin
    o_rdataA = w_rdA;
    if (i_rst_ && w_commit && (i_waddr == i_raddrA)) o_rdataA = i_wdata;
  end

  always_comb begin
    o_rdataB = w_rdB;
    if (i_rst_ && w_commit && (i_waddr == i_raddrB)) o_rdataB = i_wdata;
  end
`else
  assign o_rdataA = w_rdA;
  assign o_rdataB = w_rdB;
`endif

  always_ff @(posedge i_clk or negedge i_rst_) begin
    if (!i_rst_) begin
      r_wcnt <= '0;
    end else begin
      r_wcnt <= wcnt_next(r_wcnt, w_commit);
    end
  end

  assign o_wcnt = r_wcnt;

endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;

  logic       i_clk = 1'b0;
  logic       i_rst_;
  logic       i_we;
  logic [2:0] i_waddr;
  logic [7:0] i_wdata;
  logic [2:0] i_raddrA;
  logic [2:0] i_raddrB;
  logic [7:0] o_rdataA;
  logic [7:0] o_rdataB;
  logic [7:0] o_wcnt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mdl [8];
  int         exp_cnt;

  reg_file #(
    .DATA_W  (8),
    .ADDR_W  (3),
    .ZERO_R0 (1)
  ) dut (
    .i_clk    (i_clk),
    .i_rst_   (i_rst_),
    .i_we     (i_we),
    .i_waddr  (i_waddr),
    .i_wdata  (i_wdata),
    .i_raddrA (i_raddrA),
    .i_raddrB (i_raddrB),
    .o_rdataA (o_rdataA),
    .o_rdataB (o_rdataB),
    .o_wcnt   (o_wcnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
    exp_cnt = 0;
  endtask

  // One write committed on the next posedge; model updated alongside.
  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    i_we    = 1'b1;
    i_waddr = a;
    i_wdata = d;
    @(posedge i_clk);
    #1;
    i_we = 1'b0;
    if (a != 3'd0) begin
      mdl[a] = d;
      if (exp_cnt < 255) exp_cnt++;
    end
  endtask

  task automatic check_all(input string tag);
    for (int n = 0; n < 8; n++) begin
      i_raddrA = 3'(n);
      i_raddrB = 3'(7 - n);
      #1;
      check($sformatf("%s_A%0d", tag, n), o_rdataA, mdl[n]);
      check($sformatf("%s_B%0d", tag, 7 - n), o_rdataB, mdl[7 - n]);
    end
    check({tag, "_wcnt"}, o_wcnt, exp_cnt[7:0]);
  endtask

  initial begin
    i_rst_   = 1'b0;
    i_we     = 1'b0;
    i_waddr  = 3'd0;
    i_wdata  = 8'h00;
    i_raddrA = 3'd2;
    i_raddrB = 3'd7;
    model_clear();
    #1;
    check("reset_rdA", o_rdataA, 8'h00);
    check("reset_wcnt", o_wcnt, 8'h00);
    @(posedge i_clk);
    #1;
    i_rst_ = 1'b1;
    @(posedge i_clk);
    #1;

    // 1. Async reset between edges, then release mid-cycle and write r3.
    wr(3'd2, 8'h77);
    i_raddrA = 3'd2;
    #1;
    check("pre_rst_r2", o_rdataA, 8'h77);
    check("pre_rst_wcnt", o_wcnt, 8'h01);
    i_rst_ = 1'b0;
    #1;
    check("async_rst_r2", o_rdataA, 8'h00);
    check("async_rst_wcnt", o_wcnt, 8'h00);
    model_clear();
    #1;
    i_rst_ = 1'b1;
    wr(3'd3, 8'hA5);
    i_raddrA = 3'd3;
    #1;
    check("post_rst_r3", o_rdataA, 8'hA5);
    check("post_rst_wcnt", o_wcnt, 8'h01);

    // 2. Fill every register with 8'h10+n; r0 write is discarded.
    for (int n = 0; n < 8; n++) wr(3'(n), 8'h10 + 8'(n));
    check("fill_wcnt_const", o_wcnt, 8'h08);
    check_all("fill");

    // 3. Same-cycle write/read of r5.
    wr(3'd5, 8'h11);
    i_we     = 1'b1;
    i_waddr  = 3'd5;
    i_wdata  = 8'h3C;
    i_raddrA = 3'd5;
    i_raddrB = 3'd5;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("rw_same_A", o_rdataA, 8'h3C);
    check("rw_same_B", o_rdataB, 8'h3C);
`else
    check("rw_same_A", o_rdataA, 8'h11);
    check("rw_same_B", o_rdataB, 8'h11);
`endif
    @(posedge i_clk);
    #1;
    i_we = 1'b0;
    mdl[5] = 8'h3C;
    exp_cnt++;
    #1;
    check("rw_after_A", o_rdataA, 8'h3C);
    check("rw_after_wcnt", o_wcnt, 8'h0A);

    // Write to r0 while reading it: never forwarded, never counted.
    i_we     = 1'b1;
    i_waddr  = 3'd0;
    i_wdata  = 8'hFF;
    i_raddrA = 3'd0;
    #1;
    check("r0_same_A", o_rdataA, 8'h00);
    @(posedge i_clk);
    #1;
    i_we = 1'b0;
    #1;
    check("r0_after_A", o_rdataA, 8'h00);
    check("r0_wcnt", o_wcnt, 8'h0A);

    // 4. i_we=0 with changing address/data for 10 cycles.
    for (int c = 0; c < 10; c++) begin
      i_waddr = 3'(c);
      i_wdata = 8'(8'hC0 ^ c);
      @(posedge i_clk);
      #1;
    end
    check_all("hold");

    // 5. 300 consecutive writes to r1; counter saturates.
    for (int i = 0; i < 300; i++) begin
      wr(3'd1, 8'(i));
      if (i == 244) check("sat_reach", o_wcnt, 8'hFF);
    end
    i_raddrA = 3'd1;
    #1;
    check("sat_r1", o_rdataA, 8'h2B);
    check("sat_wcnt", o_wcnt, 8'hFF);
    check_all("sat");

    // 6. Reset asserted in the middle of a write burst.
    i_we = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_waddr = 3'(4 + i);
      i_wdata = 8'(8'h50 + i);
      @(posedge i_clk);
      #1;
    end
    i_waddr  = 3'd6;
    i_wdata  = 8'hEE;
    i_raddrA = 3'd6;
    i_raddrB = 3'd4;
    #1;
    i_rst_ = 1'b0;
    #1;
    check("burst_rst_A", o_rdataA, 8'h00);
    check("burst_rst_B", o_rdataB, 8'h00);
    check("burst_rst_wcnt", o_wcnt, 8'h00);
    @(posedge i_clk);
    #1;
    check("burst_held_A", o_rdataA, 8'h00);
    check("burst_held_wcnt", o_wcnt, 8'h00);
    i_we = 1'b0;
    #1;
    i_rst_ = 1'b1;
    @(posedge i_clk);
    #1;
    model_clear();
    check_all("burst_post");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
